// File: rtl/eh2_lsu_trig_sched.sv
// Per-thread LSU trigger-hit scheduler: pair chaining, one OR-merging pending buffer per
// thread and round-robin delivery over valid/ready. Optional feature macro: LSU_TRIG_BYPASS_EN.
module eh2_lsu_trig_sched #(
    parameter int NUM_THREADS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        lsu_trig_valid_dc4,
    input  logic                        lsu_trig_tid_dc4,
    input  logic [3:0]                  lsu_trigger_match_dc4,
    input  logic [NUM_THREADS-1:0]      lsu_flush_dc4,
    input  logic [NUM_THREADS-1:0][1:0] trig_chain,
    input  logic [NUM_THREADS-1:0][3:0] trig_action,
    input  logic [NUM_THREADS-1:0]      trig_flush,
    input  logic                        trig_hit_ready,
    output logic                        trig_hit_valid,
    output logic                        trig_hit_tid,
    output logic [3:0]                  trig_hit_vec,
    output logic                        trig_hit_halt,
    output logic                        trig_hit_merged,
    output logic [NUM_THREADS-1:0]      trig_pending
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t state, state_nxt;

    logic                        cap_tid;
    logic [3:0]                  chained_vec;
    logic                        cap_halt;
    logic                        cap;
    logic                        bypass;

    logic [NUM_THREADS-1:0]      pend_valid, pend_valid_nxt;
    logic [NUM_THREADS-1:0]      pend_halt, pend_halt_nxt;
    logic [NUM_THREADS-1:0]      pend_merged, pend_merged_nxt;
    logic [NUM_THREADS-1:0][3:0] pend_vec, pend_vec_nxt;

    logic                        slot_free;
    logic                        grant;
    logic                        gnt_tid;
    logic                        rr, rr_nxt;

    logic                        out_tid_nxt, out_halt_nxt, out_merged_nxt;
    logic [3:0]                  out_vec_nxt;

    assign cap_tid = (NUM_THREADS > 1) ? lsu_trig_tid_dc4 : 1'b0;

    always_comb begin
        chained_vec = lsu_trigger_match_dc4;
        for (int unsigned p = 0; p < 2; p++) begin
            if (trig_chain[cap_tid][p]) begin
                chained_vec[2*p]   = lsu_trigger_match_dc4[2*p] & lsu_trigger_match_dc4[2*p+1];
                chained_vec[2*p+1] = lsu_trigger_match_dc4[2*p] & lsu_trigger_match_dc4[2*p+1];
            end
        end
    end

    assign cap_halt = |(chained_vec & trig_action[cap_tid]);
    assign cap      = lsu_trig_valid_dc4 & ~lsu_flush_dc4[cap_tid] & (|chained_vec);

    assign slot_free = (state == IDLE) | trig_hit_ready;

    always_comb begin
        grant   = 1'b0;
        gnt_tid = 1'b0;
        rr_nxt  = rr;
        if (slot_free) begin
            if ((NUM_THREADS > 1) && (&pend_valid)) begin
                grant   = 1'b1;
                gnt_tid = rr;
                rr_nxt  = ~rr;
            end else if (|pend_valid) begin
                grant   = 1'b1;
                gnt_tid = (NUM_THREADS > 1) ? ~pend_valid[0] : 1'b0;
            end
        end
    end

`ifdef LSU_TRIG_BYPASS_EN
    assign bypass = (state == IDLE) & ~(|pend_valid) & cap;
`else
    assign bypass = 1'b0;
`endif

    // Grant empties the slot before capture looks at it, so a same-cycle capture loads fresh;
    // flush is applied last so it always wins.
    always_comb begin
        pend_valid_nxt  = pend_valid;
        pend_halt_nxt   = pend_halt;
        pend_merged_nxt = pend_merged;
        pend_vec_nxt    = pend_vec;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            if (grant && (gnt_tid == 1'(t)))
                pend_valid_nxt[t] = 1'b0;
            if (cap && !bypass && (cap_tid == 1'(t))) begin
                if (pend_valid_nxt[t]) begin
                    pend_vec_nxt[t]    = pend_vec[t] | chained_vec;
                    pend_halt_nxt[t]   = pend_halt[t] | cap_halt;
                    pend_merged_nxt[t] = 1'b1;
                end else begin
                    pend_vec_nxt[t]    = chained_vec;
                    pend_halt_nxt[t]   = cap_halt;
                    pend_merged_nxt[t] = 1'b0;
                end
                pend_valid_nxt[t] = 1'b1;
            end
            if (trig_flush[t])
                pend_valid_nxt[t] = 1'b0;
        end
    end

    always_comb begin
        state_nxt      = state;
        out_tid_nxt    = trig_hit_tid;
        out_vec_nxt    = trig_hit_vec;
        out_halt_nxt   = trig_hit_halt;
        out_merged_nxt = trig_hit_merged;
        if (grant) begin
            out_tid_nxt    = gnt_tid;
            out_vec_nxt    = pend_vec[gnt_tid];
            out_halt_nxt   = pend_halt[gnt_tid];
            out_merged_nxt = pend_merged[gnt_tid];
        end else if (bypass) begin
            out_tid_nxt    = cap_tid;
            out_vec_nxt    = chained_vec;
            out_halt_nxt   = cap_halt;
            out_merged_nxt = 1'b0;
        end
        case (state)
            IDLE:    if (grant || bypass) state_nxt = OFFER;
            OFFER:   if (trig_hit_ready) state_nxt = grant ? OFFER : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rr              <= 1'b0;
            pend_valid      <= '0;
            pend_halt       <= '0;
            pend_merged     <= '0;
            pend_vec        <= '0;
            trig_hit_tid    <= 1'b0;
            trig_hit_vec    <= '0;
            trig_hit_halt   <= 1'b0;
            trig_hit_merged <= 1'b0;
        end else begin
            state           <= state_nxt;
            rr              <= rr_nxt;
            pend_valid      <= pend_valid_nxt;
            pend_halt       <= pend_halt_nxt;
            pend_merged     <= pend_merged_nxt;
            pend_vec        <= pend_vec_nxt;
            trig_hit_tid    <= out_tid_nxt;
            trig_hit_vec    <= out_vec_nxt;
            trig_hit_halt   <= out_halt_nxt;
            trig_hit_merged <= out_merged_nxt;
        end
    end

    assign trig_hit_valid = (state == OFFER);
    assign trig_pending   = pend_valid;

endmodule

// File: tb/tb_eh2_lsu_trig_sched.sv
// Directed and randomized bench for eh2_lsu_trig_sched against a transaction-level model.
module tb_eh2_lsu_trig_sched;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            lsu_trig_valid_dc4 = 1'b0;
    logic            lsu_trig_tid_dc4 = 1'b0;
    logic [3:0]      lsu_trigger_match_dc4 = '0;
    logic [1:0]      lsu_flush_dc4 = '0;
    logic [1:0][1:0] trig_chain = '0;
    logic [1:0][3:0] trig_action = '0;
    logic [1:0]      trig_flush = '0;
    logic            trig_hit_ready = 1'b0;
    logic            trig_hit_valid;
    logic            trig_hit_tid;
    logic [3:0]      trig_hit_vec;
    logic            trig_hit_halt;
    logic            trig_hit_merged;
    logic [1:0]      trig_pending;

    eh2_lsu_trig_sched #(.NUM_THREADS(2)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .lsu_trig_valid_dc4    (lsu_trig_valid_dc4),
        .lsu_trig_tid_dc4      (lsu_trig_tid_dc4),
        .lsu_trigger_match_dc4 (lsu_trigger_match_dc4),
        .lsu_flush_dc4         (lsu_flush_dc4),
        .trig_chain            (trig_chain),
        .trig_action           (trig_action),
        .trig_flush            (trig_flush),
        .trig_hit_ready        (trig_hit_ready),
        .trig_hit_valid        (trig_hit_valid),
        .trig_hit_tid          (trig_hit_tid),
        .trig_hit_vec          (trig_hit_vec),
        .trig_hit_halt         (trig_hit_halt),
        .trig_hit_merged       (trig_hit_merged),
        .trig_pending          (trig_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [3:0] vec;
        bit       halt;
        bit       merged;
        bit       tid;
    } hit_t;

    hit_t buffer[2];
    hit_t offer;
    bit   offering;
    bit   rr_ptr;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        buffer[0] = '{default: 0};
        buffer[1] = '{default: 0};
        offer     = '{default: 0};
        offering  = 0;
        rr_ptr    = 0;
    endfunction

    // One clock of the scheduler, expressed in terms of hit transactions.
    function automatic void model_step();
        bit [3:0] m = lsu_trigger_match_dc4;
        bit [3:0] cv = m;
        bit       t = lsu_trig_tid_dc4;
        bit       captured, free, took, direct;
        int       g = -1;
        hit_t     h;
        for (int p = 0; p < 2; p++)
            if (trig_chain[t][p]) begin
                cv[2*p]   = m[2*p] & m[2*p+1];
                cv[2*p+1] = m[2*p] & m[2*p+1];
            end
        captured = lsu_trig_valid_dc4 && !lsu_flush_dc4[t] && (cv != 0);
        free = !offering || trig_hit_ready;
        took = 0;
        direct = 0;
        if (free) begin
            if (buffer[0].v && buffer[1].v) begin
                g = int'(rr_ptr);
                rr_ptr = !rr_ptr;
            end else if (buffer[0].v) g = 0;
            else if (buffer[1].v) g = 1;
        end
`ifdef LSU_TRIG_BYPASS_EN
        direct = !offering && (g < 0) && captured;
`endif
        if (g >= 0) begin
            offer = buffer[g];
            offer.tid = g[0];
            offering = 1;
            buffer[g].v = 0;
            took = 1;
        end else if (direct) begin
            offer = '{v: 1, vec: cv, halt: (cv & trig_action[t]) != 0, merged: 0, tid: t};
            offering = 1;
        end else if (free) begin
            offering = 0;
        end
        if (captured && !direct) begin
            h = buffer[t];
            if (h.v) begin
                h.vec    = h.vec | cv;
                h.halt   = h.halt | ((cv & trig_action[t]) != 0);
                h.merged = 1;
            end else begin
                h = '{v: 1, vec: cv, halt: (cv & trig_action[t]) != 0, merged: 0, tid: t};
            end
            buffer[t] = h;
        end
        for (int i = 0; i < 2; i++)
            if (trig_flush[i]) buffer[i].v = 0;
        if (took) begin end
    endfunction

    task automatic check_all();
        chk("valid", 8'(trig_hit_valid), 8'(offering));
        chk("pending", 8'(trig_pending), 8'({buffer[1].v, buffer[0].v}));
        if (offering) begin
            chk("tid", 8'(trig_hit_tid), 8'(offer.tid));
            chk("vec", 8'(trig_hit_vec), 8'(offer.vec));
            chk("halt", 8'(trig_hit_halt), 8'(offer.halt));
            chk("merged", 8'(trig_hit_merged), 8'(offer.merged));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic hit(input logic tid, input logic [3:0] m);
        lsu_trig_valid_dc4    = 1'b1;
        lsu_trig_tid_dc4      = tid;
        lsu_trigger_match_dc4 = m;
    endtask

    task automatic quiet();
        lsu_trig_valid_dc4    = 1'b0;
        lsu_trigger_match_dc4 = '0;
        lsu_flush_dc4         = '0;
        trig_flush            = '0;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && !trig_hit_valid; i++) tick();
        chk(tag, 8'(trig_hit_valid), 8'd1);
    endtask

    task automatic drain();
        quiet();
        trig_hit_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
    endtask

    logic first_tid;

    initial begin
        model_reset();
        trig_action[0] = 4'b0001;
        trig_action[1] = 4'b1010;
        repeat (2) @(negedge clk);
        chk("rst_valid", 8'(trig_hit_valid), 8'd0);
        chk("rst_tid", 8'(trig_hit_tid), 8'd0);
        chk("rst_vec", 8'(trig_hit_vec), 8'd0);
        chk("rst_halt", 8'(trig_hit_halt), 8'd0);
        chk("rst_merged", 8'(trig_hit_merged), 8'd0);
        chk("rst_pending", 8'(trig_pending), 8'd0);
        rst = 1'b0;
        trig_hit_ready = 1'b1;

        // Single unchained hit
        hit(1'b0, 4'b0001);
        tick();
        quiet();
        wait_valid("t1_valid", 4);
        chk("t1_vec", 8'(trig_hit_vec), 8'h1);
        chk("t1_halt", 8'(trig_hit_halt), 8'd1);
        chk("t1_merged", 8'(trig_hit_merged), 8'd0);
        chk("t1_tid", 8'(trig_hit_tid), 8'd0);
        drain();

        // Chained pair 0: half match is dropped, full match is delivered
        trig_chain[0] = 2'b01;
        hit(1'b0, 4'b0001);
        tick();
        quiet();
        tick();
        tick();
        chk("chain_half_pend", 8'(trig_pending), 8'd0);
        chk("chain_half_valid", 8'(trig_hit_valid), 8'd0);
        hit(1'b0, 4'b0011);
        tick();
        quiet();
        wait_valid("chain_full_valid", 4);
        chk("chain_full_vec", 8'(trig_hit_vec), 8'h3);
        drain();
        trig_chain = '0;

        // Back-to-back thread-1 hits under backpressure
        trig_hit_ready = 1'b0;
        hit(1'b1, 4'b0100);
        tick();
        hit(1'b1, 4'b1000);
        tick();
        quiet();
        wait_valid("bp_valid", 4);
        chk("bp_first_vec", 8'(trig_hit_vec), 8'h4);
        chk("bp_first_tid", 8'(trig_hit_tid), 8'd1);
        tick();
        chk("bp_pend1", 8'(trig_pending[1]), 8'd1);
        trig_hit_ready = 1'b1;
        tick();
        trig_hit_ready = 1'b0;
        chk("bp_second_vec", 8'(trig_hit_vec), 8'h8);
        chk("bp_second_merged", 8'(trig_hit_merged), 8'd0);

        // Merge into a full thread-0 buffer while the offer is held
        hit(1'b0, 4'b0001);
        tick();
        hit(1'b0, 4'b0010);
        tick();
        quiet();
        tick();
        chk("merge_pend0", 8'(trig_pending[0]), 8'd1);
        trig_hit_ready = 1'b1;
        tick();
        chk("merge_vec", 8'(trig_hit_vec), 8'h3);
        chk("merge_merged", 8'(trig_hit_merged), 8'd1);
        chk("merge_tid", 8'(trig_hit_tid), 8'd0);
        drain();

        // Round-robin with both threads pending, twice
        for (int round = 0; round < 2; round++) begin
            trig_hit_ready = 1'b0;
            hit(1'b0, 4'b0001);
            tick();
            hit(1'b1, 4'b0010);
            tick();
            hit(1'b0, 4'b0100);
            tick();
            quiet();
            tick();
            trig_hit_ready = 1'b1;
            tick();
            first_tid = trig_hit_tid;
            chk("rr_first", 8'(first_tid), 8'(round));
            tick();
            chk("rr_second", 8'(trig_hit_tid), 8'(!first_tid));
            drain();
        end

        // Flush wins over a same-cycle capture
        hit(1'b0, 4'b0001);
        trig_flush = 2'b01;
        tick();
        quiet();
        tick();
        chk("flush_pend0", 8'(trig_pending[0]), 8'd0);
        drain();

        // Reset during an offer drops it at once
        trig_hit_ready = 1'b0;
        hit(1'b1, 4'b0100);
        tick();
        quiet();
        wait_valid("rst_offer_valid", 4);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 8'(trig_hit_valid), 8'd0);
        chk("rst_mid_pending", 8'(trig_pending), 8'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            lsu_trig_valid_dc4    = 1'($urandom_range(0, 1));
            lsu_trig_tid_dc4      = 1'($urandom);
            lsu_trigger_match_dc4 = 4'($urandom);
            lsu_flush_dc4         = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            trig_chain            = 4'($urandom);
            trig_flush            = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            trig_hit_ready        = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) trig_action = 8'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
